// File: rtl/barrett_pkg.sv
// Shared helpers for the Barrett reducer family.
// Width derivation and Barrett constant generation from the modulus.
package barrett_pkg;

  localparam int TAG_W_DEF = 8;

  function automatic int calc_qw(input int q);
    return $clog2(q);
  endfunction

  function automatic int calc_in_w(input int qw);
    return 2 * qw - 1;
  endfunction

  // floor(2^(2*qw) / q)
  function automatic longint unsigned calc_mu(input int q, input int qw);
    longint unsigned num;
    num = 64'd1 << (2 * qw);
    return num / 64'(q);
  endfunction

endpackage

// File: rtl/barrett_mod_correct.sv
// Final Barrett correction: folds a remainder known to be below 3Q into [0, Q-1].
module barrett_mod_correct import barrett_pkg::*; #(
  parameter int Q  = 2213,
  parameter int QW = calc_qw(Q)
) (
  input  logic [QW+1:0] r_i,
  output logic [QW-1:0] r_o
);

  localparam logic [QW+1:0] Q1 = (QW+2)'(Q);
  localparam logic [QW+1:0] Q2 = (QW+2)'(2 * Q);

  always_comb begin
    if (r_i >= Q2) begin
      r_o = QW'(r_i - Q2);
    end else if (r_i >= Q1) begin
      r_o = QW'(r_i - Q1);
    end else begin
      r_o = QW'(r_i);
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer (dout = din mod Q) with valid/ready
// backpressure and an opaque sideband tag carried alongside each beat.
module barrett_reduce_pipe import barrett_pkg::*; #(
  parameter int Q     = 2213,
  parameter int QW    = calc_qw(Q),
  parameter int IN_W  = calc_in_w(QW),
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    dout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = IN_W + 1;
  localparam int TW = PW - QW;
  localparam int XW = PW + QW;
  localparam logic [QW:0]   MU  = (QW+1)'(calc_mu(Q, QW));
  localparam logic [XW-1:0] Q_X = XW'(Q);

  if (IN_W > 2 * QW || (Q % 2) == 0 || Q < 3) begin : g_param_err
    $error("barrett_reduce_pipe: illegal parameters Q=%0d QW=%0d IN_W=%0d", Q, QW, IN_W);
  end

  typedef struct packed {
    logic [QW+1:0]    data;
    logic [TAG_W-1:0] tag;
  } s2_pay_t;

  logic                 en;
  logic [IN_W-QW-1:0]   q1;
  logic [TW-1:0]        t;
  logic [QW-1:0]        corr;

  logic                 vld_p1_q, vld_p1_d;
  logic [PW-1:0]        prod_p1_q, prod_p1_d;
  logic [IN_W-1:0]      din_p1_q, din_p1_d;
  logic [TAG_W-1:0]     tag_p1_q, tag_p1_d;
  logic                 vld_p2_q, vld_p2_d;
  s2_pay_t              pay_p2_q, pay_p2_d;
  logic                 vld_p3_q, vld_p3_d;
  logic [QW-1:0]        dout_p3_q, dout_p3_d;
  logic [TAG_W-1:0]     tag_p3_q, tag_p3_d;

  always_comb begin
    en = !vld_p3_q || out_ready;
    q1 = (IN_W-QW)'(din >> QW);
    t  = TW'(prod_p1_q >> QW);

    vld_p1_d  = vld_p1_q;
    prod_p1_d = prod_p1_q;
    din_p1_d  = din_p1_q;
    tag_p1_d  = tag_p1_q;
    vld_p2_d  = vld_p2_q;
    pay_p2_d  = pay_p2_q;
    vld_p3_d  = vld_p3_q;
    dout_p3_d = dout_p3_q;
    tag_p3_d  = tag_p3_q;

    if (en) begin
      // S1: quotient estimate product, full width
      vld_p1_d  = in_valid;
      prod_p1_d = PW'(q1) * PW'(MU);
      din_p1_d  = din;
      tag_p1_d  = in_tag;
      // S2: remainder estimate; true value is below 3Q so QW+2 bits suffice
      vld_p2_d      = vld_p1_q;
      pay_p2_d.data = (QW+2)'(XW'(din_p1_q) - XW'(t) * Q_X);
      pay_p2_d.tag  = tag_p1_q;
      // S3: final correction into [0, Q-1]
      vld_p3_d  = vld_p2_q;
      dout_p3_d = corr;
      tag_p3_d  = pay_p2_q.tag;
    end
  end

  barrett_mod_correct #(.Q(Q), .QW(QW)) u_corr (
    .r_i (pay_p2_q.data),
    .r_o (corr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      dout_p3_q <= '0;
      tag_p3_q  <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      dout_p3_q <= dout_p3_d;
      tag_p3_q  <= tag_p3_d;
    end
  end

  // Internal data stages are qualified by their valids and need no reset.
  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    din_p1_q  <= din_p1_d;
    tag_p1_q  <= tag_p1_d;
    pay_p2_q  <= pay_p2_d;
  end

  assign in_ready  = en;
  assign out_valid = vld_p3_q;
  assign dout      = dout_p3_q;
  assign out_tag   = tag_p3_q;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed bench for barrett_reduce_pipe at Q=2213 (QW=12, IN_W=23).
module tb_barrett_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] din;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dout;
  logic [7:0]  out_tag;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [22:0] st_v [9] = '{23'd100, 23'd5000, 23'd12345, 23'd1000000, 23'd7777777,
                            23'd4194304, 23'd65535, 23'd3000000, 23'd6638};
  logic [11:0] st_e [9] = '{12'd100, 12'd574, 12'd1280, 12'd1937, 12'd1295,
                            12'd669, 12'd1358, 12'd1385, 12'd2212};
  logic [22:0] bp_v [5] = '{23'd10, 23'd2213, 23'd4430, 23'd8388607, 23'd2212};
  logic [11:0] bp_e [5] = '{12'd10, 12'd0, 12'd4, 12'd1337, 12'd2212};

  barrett_reduce_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic single(input logic [22:0] v, input logic [7:0] tg, input logic [11:0] exp);
    @(negedge clk);
    din = v; in_tag = tg; in_valid = 1'b1;
    #1;
    check("single_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("single_lat1", out_valid, 0);
    @(negedge clk);
    check("single_lat2", out_valid, 0);
    @(negedge clk);
    check("single_lat3_valid", out_valid, 1);
    check("single_dout", dout, exp);
    check("single_tag", out_tag, tg);
  endtask

  initial begin
    int  acc;
    int  got;
    bit  pend;

    rst = 1'b1; in_valid = 1'b0; din = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    single(23'd0,       8'h01, 12'd0);
    single(23'd2212,    8'h02, 12'd2212);
    single(23'd2213,    8'h03, 12'd0);
    single(23'd4426,    8'h04, 12'd0);
    single(23'd4194303, 8'h05, 12'd668);
    single(23'd8388607, 8'h06, 12'd1337);
    single(23'd8387270, 8'h07, 12'd0);
    single(23'd4425,    8'h08, 12'd2212);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check("stream_valid", out_valid, 1);
        check("stream_dout", dout, st_e[i-3]);
        check("stream_tag", out_tag, 8'h40 + 8'(i-3));
      end else begin
        check("stream_fill", out_valid, 0);
      end
      if (i < 9) begin
        din = st_v[i]; in_tag = 8'h40 + 8'(i); in_valid = 1'b1;
        #1;
        check("stream_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stream_drained", out_valid, 0);

    acc = 0; got = 0; pend = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pend) acc++;
      if (c >= 3) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_dout", dout, bp_e[0]);
        check("bp_hold_tag", out_tag, 8'hA0);
      end
      din = bp_v[acc]; in_tag = 8'hA0 + 8'(acc); in_valid = 1'b1;
      #1;
      check("bp_in_ready", in_ready, (c < 3) ? 1 : 0);
      pend = in_ready;
    end
    check("bp_accepted", acc, 3);

    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      if (pend) acc++;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        check("bp_rel_dout", dout, bp_e[got]);
        check("bp_rel_tag", out_tag, 8'hA0 + 8'(got));
        got++;
      end
      if (acc < 5) begin
        din = bp_v[acc]; in_tag = 8'hA0 + 8'(acc); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      pend = in_valid && in_ready;
    end
    check("bp_out_count", got, 5);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_no_dup", out_valid, 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = st_v[i]; in_tag = 8'hC0 + 8'(i); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_dout", dout, 0);
    check("async_rst_tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_empty", out_valid, 0);
    end
    single(23'd4194303, 8'h77, 12'd668);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
